// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: drives a 4-digit multiplexed seven-segment display from a signed
// 8-bit value. New values are captured on a load strobe and applied only at a frame
// boundary, so one frame never mixes two values. Contains the combinational
// number_formatter (sign + three BCD digits) used by the scan controller.

// number_formatter: signed 8-bit value -> active-low segment codes for sign and 3 digits.
module number_formatter #(
   parameter int unsigned BLANK_ZEROS = 1
) (
   input  logic [7:0] value_i,
   output logic [6:0] seg_sign_o,
   output logic [6:0] seg_hund_o,
   output logic [6:0] seg_tens_o,
   output logic [6:0] seg_units_o
);

   localparam logic [6:0] SegMinus = 7'b0111111;
   localparam logic [6:0] SegBlank = 7'b1111111;

   logic [7:0] mag;
   logic [3:0] hund;
   logic [3:0] tens;
   logic [3:0] units;
   logic       hund_blank;
   logic       tens_blank;

   // Active-low {g,f,e,d,c,b,a} code for one BCD digit; non-BCD input shows blank.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SegBlank;
      endcase
      return s;
   endfunction

   // Magnitude and BCD split; -128 negates to 0x80, which reads correctly as unsigned 128.
   always_comb begin
      mag   = value_i[7] ? (~value_i + 8'd1) : value_i;
      hund  = 4'(mag / 8'd100);
      tens  = 4'((mag % 8'd100) / 8'd10);
      units = 4'(mag % 8'd10);
   end

   // Leading-zero suppression and final segment selection.
   always_comb begin
      hund_blank  = (BLANK_ZEROS != 0) && (hund == 4'd0);
      tens_blank  = hund_blank && (tens == 4'd0);
      seg_sign_o  = value_i[7] ? SegMinus : SegBlank;
      seg_hund_o  = hund_blank ? SegBlank : digit_to_seg(hund);
      seg_tens_o  = tens_blank ? SegBlank : digit_to_seg(tens);
      seg_units_o = digit_to_seg(units);
   end

endmodule

// seg7_scan_controller: slot/digit sequencing, deferred load, guard-banded anode drive.
module seg7_scan_controller #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned GUARD_CYCLES = 16,
   parameter int unsigned BLANK_ZEROS  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       load,
   output logic       applied,
   output logic [7:0] shown_value,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int unsigned     CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] CntGuard = CntW'(GUARD_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      value_q, value_d;
   logic            pending_q, pending_d;
   logic [7:0]      pend_data_q, pend_data_d;
   logic            applied_q, applied_d;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      an_q, an_d;

   logic            slot_end;
   logic            frame_end;
   logic [6:0]      seg_sign;
   logic [6:0]      seg_hund;
   logic [6:0]      seg_tens;
   logic [6:0]      seg_units;

   number_formatter #(
      .BLANK_ZEROS (BLANK_ZEROS)
   ) u_formatter (
      .value_i     (value_q),
      .seg_sign_o  (seg_sign),
      .seg_hund_o  (seg_hund),
      .seg_tens_o  (seg_tens),
      .seg_units_o (seg_units)
   );

   assign slot_end  = (cnt_q == CntLast);
   assign frame_end = slot_end && (idx_q == 2'd3);

   // Slot counter, digit index and deferred value update.
   always_comb begin
      cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
      idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
      value_d     = value_q;
      pending_d   = pending_q;
      pend_data_d = pend_data_q;
      applied_d   = 1'b0;
      if (load) begin
         pending_d   = 1'b1;
         pend_data_d = data_in;
      end
      if (frame_end) begin
         // A load landing on the boundary bypasses the pending buffer.
         if (load) begin
            value_d   = data_in;
            applied_d = 1'b1;
         end else if (pending_q) begin
            value_d   = pend_data_q;
            applied_d = 1'b1;
         end
         pending_d = 1'b0;
      end
   end

   // Digit select and anode drive, blanked during the guard at the start of each slot.
   always_comb begin
      case (idx_q)
         2'd3:    seg_d = seg_sign;
         2'd2:    seg_d = seg_hund;
         2'd1:    seg_d = seg_tens;
         default: seg_d = seg_units;
      endcase
      an_d = 4'b1111;
      if (cnt_q >= CntGuard) begin
         an_d[idx_q] = 1'b0;
      end
   end

   // State and registered display outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         value_q     <= 8'h00;
         pending_q   <= 1'b0;
         pend_data_q <= 8'h00;
         applied_q   <= 1'b0;
         seg_q       <= 7'b1111111;
         an_q        <= 4'b1111;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         value_q     <= value_d;
         pending_q   <= pending_d;
         pend_data_q <= pend_data_d;
         applied_q   <= applied_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign applied     = applied_q;
   assign shown_value = value_q;
   assign seg         = seg_q;
   assign an          = an_q;
   assign dp          = 1'b1;

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Sequencer that drives the board's 4-digit multiplexed seven-segment display from an 8-bit signed ALU result. It captures a new value through a load strobe and defers the update to the next frame boundary so a frame never shows mixed values. It converts the value to sign plus three BCD digits with a combinational `number_formatter` instance, then time-multiplexes the anodes, inserting a ghost-suppression guard at every digit change. It sits between the ALU result register and the top-level display pins.

## Interface
- `REFRESH_DIV`, 100000, clock cycles per digit slot (≥ `GUARD_CYCLES`+1).
- `GUARD_CYCLES`, 16, cycles at the start of each slot with all anodes off.
- `BLANK_ZEROS`, 1, when 1, leading-zero hundreds and tens digits are blanked.
- `clk` in 1, system clock.
- `rst_n` in 1, synchronous, active-low reset.
- `data_in` in 8, two's-complement value to display.
- `load` in 1, single-cycle strobe; captures `data_in`.
- `applied` out 1, one-cycle pulse when a captured value becomes the displayed value.
- `shown_value` out 8, value currently displayed (`value_q`).
- `seg` out 7, active-low segments {g,f,e,d,c,b,a}.
- `an` out 4, active-low anodes; `an[3]` is leftmost.
- `dp` out 1, decimal point; constant 1 (off).

## Operation
- Slot counter `cnt` counts 0..`REFRESH_DIV`-1. At the terminal count it wraps to 0 and digit index `idx` advances 0→1→2→3→0.
- Frame boundary is the cycle where `cnt`=`REFRESH_DIV`-1 and `idx`=3.
- Digit map:
  - `idx` 3: sign; '-' if `value_q[7]`, else blank.
  - `idx` 2: hundreds.
  - `idx` 1: tens.
  - `idx` 0: units.
- Magnitude: |−128| = 128 renders as "-128".
- Blanking with `BLANK_ZEROS`=1:
  - Hundreds is blanked if 0.
  - Tens is blanked if hundreds and tens are both 0.
  - Units is always shown.
- Segment codes (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - minus=0111111, blank=1111111.
- Guard: while `cnt` < `GUARD_CYCLES`, `an`=1111. Otherwise `an` has only bit `idx` low.
- Load handling:
  - `load`=1 sets `pending`=1 and `pend_data`=`data_in`.
  - Repeated loads before the boundary overwrite `pend_data` (last wins).
- At the frame boundary with `pending`=1: `value_q`←`pend_data`, `pending`←0, `applied` pulses in the next cycle.
- `load` coinciding with a frame boundary: `data_in` goes straight to `value_q`, `pending` ends at 0, and exactly one `applied` pulse is produced.
- Boundary with no pending load: `value_q` is unchanged and there is no pulse.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - `cnt`=0, `idx`=0, `value_q`=0x00, `pending`=0, `pend_data`=0.
  - `applied`=0, `an`=1111, `seg`=1111111, `dp`=1, `shown_value`=0x00.
- Reset mid-frame or with a load pending discards the pending data. No `applied` pulse occurs.
- `seg` and `an` are registered from the same-cycle `cnt`/`idx`/`value_q`, giving 1-cycle output latency.
- `shown_value` equals `value_q` with no extra delay. It changes in the same cycle `applied` asserts.
- Load-to-display latency ranges from 1 cycle (load at boundary) to 4·`REFRESH_DIV` cycles.
- Frame period is 4·`REFRESH_DIV` cycles. Each anode is active for `REFRESH_DIV`−`GUARD_CYCLES` cycles per frame.
- `an` and `seg` change only at slot start. `seg` may change during the guard while `an`=1111.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `GUARD_CYCLES`=2.
- Reset: hold `rst_n`=0 for 3 cycles → `an`=1111, `seg`=1111111, `shown_value`=0, `applied`=0. After release, `an[0]` goes low at cycle 3 with `seg`=1000000 (units '0'), and all other digits are blank.
- Load 0x85 (−123) at cycle 5 → a single `applied` at the first boundary. The next frame shows an3 0111111, an2 1111001, an1 0100100, an0 0110000, with 2 guard cycles of `an`=1111 per slot.
- Load 0x05 → an3, an2 and an1 are blank (1111111); an0 shows 0010010. Repeat with `BLANK_ZEROS`=0 → an2 and an1 show 1000000.
- Load 0x80 → "-128" (0111111, 1111001, 0100100, 0000000). Load 0x7F → blank, '1', '2', '7'.
- Load 0x10 then 0x22 within one frame → one `applied` pulse and `shown_value`=0x22. Load exactly on a boundary cycle → `shown_value` updates the next cycle.
- Load 0x85, then assert `rst_n`=0 before the boundary → no `applied` pulse, and `shown_value` stays 0x00 after reset.
